// File: rtl/hazard_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W  = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned MEM_TIMEOUT = 255;
  localparam int unsigned WAIT_W      = 8;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1
  } pipe_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-side signal bundle of the hazard sequencer; master is the pipeline, slave the sequencer.
interface hazard_sequencer_if;
  import pipe_ctrl_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic                  ex_wb_en;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  mem_wb_en;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  clr_cnt;

  logic                  pc_freeze;
  logic                  if_id_freeze;
  logic                  id_ex_freeze;
  logic                  ex_mem_freeze;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
  logic                  mem_err;
  logic [1:0]            state;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, ex_wb_en, ex_mem_read, ex_dst,
           mem_wb_en, mem_dst, ex_branch_taken, mem_req, mem_ready, clr_cnt,
    input  pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, if_id_flush, id_ex_flush,
           stall_cnt, flush_cnt, mem_err, state
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, ex_wb_en, ex_mem_read, ex_dst,
           mem_wb_en, mem_dst, ex_branch_taken, mem_req, mem_ready, clr_cnt,
    output pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, if_id_flush, id_ex_flush,
           stall_cnt, flush_cnt, mem_err, state
  );

endinterface

// File: rtl/hazard_sequencer_detect.sv
// Source/destination register match for one producing stage.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_src1,
  input  logic [REG_ADDR_W-1:0] i_src2,
  input  logic                  i_two_src,
  input  logic [REG_ADDR_W-1:0] i_dst,
  output logic                  o_match
);

  logic w_src1_hit;
  logic w_src2_hit;

  assign w_src1_hit = (i_src1 == i_dst);
  assign w_src2_hit = i_two_src & (i_src2 == i_dst);
  assign o_match    = i_id_valid & (w_src1_hit | w_src2_hit);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline freeze/flush sequencer: memory wait > taken branch > data hazard.
// Build option FORWARDING_EN: only an EX load-use dependency stalls.
module hazard_sequencer
  import pipe_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  hazard_sequencer_if.slave io_ctrl
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_next;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_mem_err;

  logic w_ex_match;
  logic w_hazard;
  logic w_mem_frz;
  logic w_branch;
  logic w_data_stall;

  hazard_detect u_detect_ex (
    .i_id_valid (io_ctrl.id_valid),
    .i_src1     (io_ctrl.id_src1),
    .i_src2     (io_ctrl.id_src2),
    .i_two_src  (io_ctrl.id_two_src),
    .i_dst      (io_ctrl.ex_dst),
    .o_match    (w_ex_match)
  );

`ifdef FORWARDING_EN
  logic w_unused_fwd;
  assign w_unused_fwd = ^{io_ctrl.mem_wb_en, io_ctrl.mem_dst};
  assign w_hazard     = io_ctrl.ex_wb_en & io_ctrl.ex_mem_read & w_ex_match;
`else
  logic w_mem_match;
  logic w_unused_nofwd;

  hazard_detect u_detect_mem (
    .i_id_valid (io_ctrl.id_valid),
    .i_src1     (io_ctrl.id_src1),
    .i_src2     (io_ctrl.id_src2),
    .i_two_src  (io_ctrl.id_two_src),
    .i_dst      (io_ctrl.mem_dst),
    .o_match    (w_mem_match)
  );

  assign w_unused_nofwd = io_ctrl.ex_mem_read;
  assign w_hazard       = (io_ctrl.ex_wb_en & w_ex_match) | (io_ctrl.mem_wb_en & w_mem_match);
`endif

  // The acknowledge cycle in MEM_WAIT releases the pipeline, so only unacknowledged cycles freeze.
  always_comb begin
    w_state_next = StRun;
    w_mem_frz    = 1'b0;
    case (r_state)
      StRun: begin
        w_mem_frz    = io_ctrl.mem_req & ~io_ctrl.mem_ready;
        w_state_next = w_mem_frz ? StMemWait : StRun;
      end
      StMemWait: begin
        w_mem_frz    = ~io_ctrl.mem_ready;
        w_state_next = io_ctrl.mem_ready ? StRun : StMemWait;
      end
      default: begin
        w_mem_frz    = 1'b0;
        w_state_next = StRun;
      end
    endcase

    w_branch     = ~w_mem_frz & io_ctrl.ex_branch_taken;
    w_data_stall = ~w_mem_frz & ~io_ctrl.ex_branch_taken & w_hazard;

    w_wait_next = '0;
    if ((r_state == StMemWait) && !io_ctrl.mem_ready) begin
      w_wait_next = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
    end
  end

  assign io_ctrl.pc_freeze     = w_mem_frz | w_data_stall;
  assign io_ctrl.if_id_freeze  = w_mem_frz | w_data_stall;
  assign io_ctrl.id_ex_freeze  = w_mem_frz;
  assign io_ctrl.ex_mem_freeze = w_mem_frz;
  assign io_ctrl.if_id_flush   = w_branch;
  assign io_ctrl.id_ex_flush   = w_branch | w_data_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StRun;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_wait_next == WAIT_MAX) begin
        r_mem_err <= 1'b1;
      end
      if (io_ctrl.clr_cnt) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (io_ctrl.pc_freeze) begin
          r_stall_cnt <= sat_inc(r_stall_cnt);
        end
        if (w_branch) begin
          r_flush_cnt <= sat_inc(r_flush_cnt);
        end
      end
    end
  end

  assign io_ctrl.stall_cnt = r_stall_cnt;
  assign io_ctrl.flush_cnt = r_flush_cnt;
  assign io_ctrl.mem_err   = r_mem_err;
  assign io_ctrl.state     = r_state;

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: id_valid  in  1  ID stage holds a real instruction.
REQ-004 SHALL have port: id_src1, id_src2  in  4 each  ID source register numbers.
REQ-005 SHALL have port: id_two_src  in  1  id_src2 is read by the ID instruction.
REQ-006 SHALL have port: ex_wb_en, ex_mem_read  in  1 each  EX write-back enable and load flag.
REQ-007 SHALL have port: ex_dst  in  4  EX destination register.
REQ-008 SHALL have port: mem_wb_en  in  1  MEM write-back enable; mem_dst  in  4  MEM destination register.
REQ-009 SHALL have port: ex_branch_taken  in  1  taken branch resolved in EX.
REQ-010 SHALL have port: mem_req  in  1  MEM stage memory access; mem_ready  in  1  memory acknowledge.
REQ-011 SHALL have port: clr_cnt  in  1  synchronous counter clear.
REQ-012 SHALL have port: pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze  out  1 each  hold stage registers.
REQ-013 SHALL have port: if_id_flush, id_ex_flush  out  1 each  zero stage registers (bubble).
REQ-014 SHALL have port: stall_cnt, flush_cnt  out  16 each  event counters; mem_err  out  1  sticky timeout flag; state  out  2  FSM state.

Function
REQ-015 SHALL implement FSM states RUN=0 and MEM_WAIT=1; codes 2 and 3 are unused and SHALL recover to RUN.
REQ-016 RUN→MEM_WAIT SHALL occur when mem_req=1 and mem_ready=0; MEM_WAIT→RUN SHALL occur on the first cycle with mem_ready=1.
REQ-017 In MEM_WAIT, and in RUN whenever mem_req=1 and mem_ready=0, all four freezes SHALL be 1 and both flushes SHALL be 0.
REQ-018 Match SHALL be (id_src1==dst) or (id_two_src and id_src2==dst), gated by id_valid.
REQ-019 Branch: when not memory-frozen and ex_branch_taken=1, if_id_flush=id_ex_flush=1 in that same cycle and no freeze SHALL assert.
REQ-020 Data hazard: when neither memory-frozen nor branching, a hazard SHALL assert pc_freeze=if_id_freeze=1 and id_ex_flush=1.
REQ-021 Priority SHALL be memory wait > branch > data hazard.
REQ-022 Freeze and flush outputs SHALL be combinational from state and inputs; the counters, mem_err and state SHALL be registered.
REQ-023 stall_cnt SHALL increment on each cycle with pc_freeze=1; flush_cnt SHALL increment on each branch-flush cycle; both SHALL saturate at 0xFFFF.
REQ-024 clr_cnt=1 SHALL zero both counters on the next edge, taking priority over increment.
REQ-025 A wait counter SHALL count consecutive MEM_WAIT cycles; reaching 255 SHALL set mem_err sticky until rst, and the FSM SHALL keep waiting.

Reset
REQ-026 rst SHALL immediately force state=RUN, stall_cnt=0, flush_cnt=0, mem_err=0 and wait counter=0; freezes and flushes then follow REQ-016..021.
REQ-027 rst asserted mid-MEM_WAIT SHALL abandon the wait without a flush.

Configuration
REQ-028 Macro FORWARDING_EN defined: hazard = ex_wb_en and ex_mem_read and match(ex_dst), giving a 1-cycle load-use stall only.
REQ-029 Macro FORWARDING_EN undefined: hazard = (ex_wb_en and match(ex_dst)) or (mem_wb_en and match(mem_dst)).

Structure
REQ-030 Package pipe_ctrl_pkg SHALL hold the state enum, REG_ADDR_W=4, CNT_W=16 and MEM_TIMEOUT=255.
REQ-031 Match logic SHALL be a sub-module hazard_detect, instantiated once per destination compared.

Verification
REQ-032 ex_wb_en=1, ex_mem_read=1, ex_dst=3, id_src1=3, id_valid=1 -> pc_freeze=if_id_freeze=id_ex_flush=1 for 1 cycle, stall_cnt=1.
REQ-033 Without FORWARDING_EN: mem_wb_en=1, mem_dst=5, id_two_src=1, id_src2=5 -> stall; with FORWARDING_EN -> no stall.
REQ-034 ex_branch_taken=1 together with a load-use hazard -> both flushes=1, pc_freeze=0, flush_cnt=1.
REQ-035 mem_req=1 with mem_ready=0 for 4 cycles, then mem_ready=1 -> all freezes=1 for 4 cycles, state returns to RUN, stall_cnt=4.
REQ-036 mem_ready held 0 for 300 cycles -> mem_err=1 after 255 cycles; rst -> mem_err=0, state=RUN.
REQ-037 Preload stall_cnt=0xFFFF, then stall -> stays 0xFFFF; clr_cnt=1 during a stall -> 0.
